// File: rtl/ifetch_if.sv
// rtl/ifetch_if.sv - icache, decoder, redirect and branch-commit signals of the fetch unit
interface ifetch_if;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_valid;
    logic [31:0] icache_instr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        is_jump_instr;
    logic        jump_prediction;
    logic        stall_IF;
    logic        flush;
    logic [31:0] flush_pc;
    logic        br_commit;
    logic [31:0] br_pc;
    logic        br_taken;

    modport master (
        output icache_req, icache_addr, instr_valid, instr, instr_pc, is_jump_instr, jump_prediction,
        input  icache_valid, icache_instr, stall_IF, flush, flush_pc, br_commit, br_pc, br_taken
    );

    modport slave (
        input  icache_req, icache_addr, instr_valid, instr, instr_pc, is_jump_instr, jump_prediction,
        output icache_valid, icache_instr, stall_IF, flush, flush_pc, br_commit, br_pc, br_taken
    );
endinterface

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch unit; optional 2-bit BHT branch prediction under IFETCH_BHT_EN
module ifetch #(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int          BHT_ENTRIES = 256
) (
    input logic      clk,
    input logic      rst,
    input logic      rdy,
    ifetch_if.master bus
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD, DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        is_jump_q, is_jump_d;
    logic        pred_q, pred_d;

    logic [6:0]  opcode;
    logic        is_jal, is_jalr, is_branch, br_pred;
    logic [31:0] j_imm, b_imm;
    logic        outstanding;

    assign opcode    = bus.icache_instr[6:0];
    assign is_jal    = (opcode == 7'b1101111);
    assign is_jalr   = (opcode == 7'b1100111);
    assign is_branch = (opcode == 7'b1100011);
    assign j_imm = {{12{bus.icache_instr[31]}}, bus.icache_instr[19:12], bus.icache_instr[20],
                    bus.icache_instr[30:21], 1'b0};
    assign b_imm = {{20{bus.icache_instr[31]}}, bus.icache_instr[7], bus.icache_instr[30:25],
                    bus.icache_instr[11:8], 1'b0};

`ifdef IFETCH_BHT_EN
    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [IDX_W-1:0] lookup_idx, update_idx;
    logic             unused_br;

    assign lookup_idx = pc_q[IDX_W+1:2];
    assign update_idx = bus.br_pc[IDX_W+1:2];
    assign br_pred    = bht_q[lookup_idx][1];
    assign unused_br  = ^{bus.br_pc[31:IDX_W+2], bus.br_pc[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (rdy && bus.br_commit) begin
            if (bus.br_taken && bht_q[update_idx] != 2'b11) begin
                bht_q[update_idx] <= bht_q[update_idx] + 2'b01;
            end else if (!bus.br_taken && bht_q[update_idx] != 2'b00) begin
                bht_q[update_idx] <= bht_q[update_idx] - 2'b01;
            end
        end
    end
`else
    logic unused_br;

    assign br_pred   = 1'b0;
    assign unused_br = ^{bus.br_commit, bus.br_pc, bus.br_taken};
`endif

    // IDLE counts as outstanding: the icache latches the request on the same edge.
    assign outstanding = (state_q == IDLE) || (state_q == WAIT) || (state_q == DROP);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        is_jump_d     = is_jump_q;
        pred_d        = pred_q;
        if (bus.flush) begin
            pc_d          = bus.flush_pc;
            instr_valid_d = 1'b0;
            state_d       = (outstanding && !bus.icache_valid) ? DROP : IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = WAIT;
                WAIT: begin
                    if (bus.icache_valid) begin
                        instr_d       = bus.icache_instr;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        is_jump_d     = is_jal || is_jalr || is_branch;
                        pred_d        = is_jal || (is_branch && br_pred);
                        if (is_jal) begin
                            pc_d = pc_q + j_imm;
                        end else if (is_branch && br_pred) begin
                            pc_d = pc_q + b_imm;
                        end else begin
                            pc_d = pc_q + 32'd4;
                        end
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (!bus.stall_IF) begin
                        instr_valid_d = 1'b0;
                        state_d       = IDLE;
                    end
                end
                DROP: begin
                    if (bus.icache_valid) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
            instr_valid_q <= 1'b0;
            is_jump_q     <= 1'b0;
            pred_q        <= 1'b0;
        end else if (rdy) begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            is_jump_q     <= is_jump_d;
            pred_q        <= pred_d;
        end
    end

    assign bus.icache_req      = !rst && ((state_q == IDLE) || (state_q == WAIT));
    assign bus.icache_addr     = pc_q;
    assign bus.instr_valid     = instr_valid_q;
    assign bus.instr           = instr_q;
    assign bus.instr_pc        = instr_pc_q;
    assign bus.is_jump_instr   = is_jump_q;
    assign bus.jump_prediction = pred_q;
endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - randomized scoreboard bench for ifetch with a behavioural fetch-stream model
module tb_ifetch;
    localparam int          BHT_N = 256;
    localparam logic [31:0] RPC   = 32'h0;
    localparam int          NCYC  = 3000;
    localparam int          K_OTHER = 0, K_JAL = 1, K_BR = 2, K_JALR = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        isj;
        logic        pred;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;

    ifetch_if bus();

    ifetch #(.RESET_PC(RPC), .BHT_ENTRIES(BHT_N)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];

    logic [31:0] m_pc = RPC;
    int          epoch = 0;
    bit          busy = 0;
    int          cnt = 0;
    logic [31:0] r_addr, r_instr, r_imm;
    int          r_kind, r_epoch;
    bit          holding = 0;
    logic [31:0] last_br_pc = 32'h0;
`ifdef IFETCH_BHT_EN
    int          bht [BHT_N];
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic gen_instr(output logic [31:0] ins, output int kind, output logic [31:0] imm);
        int          r;
        logic [31:0] x;
        logic [6:0]  opc;
        r = $urandom_range(0, 9);
        x = $urandom;
        imm = 32'h0;
        if (r < 3) begin
            kind = K_JAL;
            imm  = {{11{x[20]}}, x[20:2], 2'b00};
            ins  = {imm[20], imm[10:1], imm[11], imm[19:12], x[11:7], 7'b1101111};
        end else if (r < 6) begin
            kind = K_BR;
            imm  = {{19{x[12]}}, x[12:2], 2'b00};
            ins  = {imm[12], imm[10:5], x[24:20], x[19:15], x[14:12], imm[4:1], imm[11], 7'b1100011};
        end else if (r < 7) begin
            kind = K_JALR;
            ins  = {x[31:7], 7'b1100111};
        end else begin
            kind = K_OTHER;
            case ($urandom_range(0, 4))
                0:       opc = 7'b0010011;
                1:       opc = 7'b0110011;
                2:       opc = 7'b0000011;
                3:       opc = 7'b0100011;
                default: opc = 7'b0110111;
            endcase
            ins = {x[31:7], opc};
        end
    endtask

    function automatic int bidx(input logic [31:0] a);
        return int'((a >> 2) % BHT_N);
    endfunction

    // A response reaching the decoder: prediction from the pre-update counters.
    task automatic deliver();
        exp_t        e;
        bit          pred;
        logic [31:0] next;
        pred = 1'b0;
        next = r_addr + 32'd4;
        if (r_kind == K_JAL) begin
            pred = 1'b1;
            next = r_addr + r_imm;
        end else if (r_kind == K_BR) begin
`ifdef IFETCH_BHT_EN
            pred = (bht[bidx(r_addr)] >= 2);
`endif
            if (pred) next = r_addr + r_imm;
            last_br_pc = r_addr;
        end
        e.pc    = r_addr;
        e.instr = r_instr;
        e.isj   = (r_kind != K_OTHER);
        e.pred  = pred;
        sb_q.push_back(e);
        m_pc    = next;
        holding = 1'b1;
    endtask

    // Applies what the coming clock edge does, given this cycle's inputs.
    task automatic model_edge();
        bit exp_req, resp, accept, hold0;
        if (rst) begin
            check("req_in_reset", bus.icache_req, 0);
            m_pc = RPC; epoch = 0; busy = 0; holding = 0; cnt = 0;
            sb_q.delete();
`ifdef IFETCH_BHT_EN
            for (int i = 0; i < BHT_N; i++) bht[i] = 1;
`endif
            return;
        end
        exp_req = !holding && !(busy && r_epoch != epoch);
        check("icache_req", bus.icache_req, exp_req);
        if (exp_req && bus.icache_req) check("icache_addr", bus.icache_addr, m_pc);
        if (!rdy) return;
        resp   = busy && (cnt == 0);
        accept = bus.icache_req && !busy;
        hold0  = holding;
        if (resp) begin
            busy = 0;
            if (!bus.flush && r_epoch == epoch) deliver();
        end else if (busy && cnt > 0) begin
            cnt--;
        end
        if (hold0 && !bus.stall_IF) holding = 0;
        if (accept) begin
            busy    = 1;
            cnt     = $urandom_range(0, 3);
            r_addr  = bus.icache_addr;
            r_epoch = epoch;
            gen_instr(r_instr, r_kind, r_imm);
        end
        if (bus.flush) begin
            epoch++;
            m_pc    = bus.flush_pc;
            holding = 0;
        end
`ifdef IFETCH_BHT_EN
        if (bus.br_commit) begin
            if (bus.br_taken) bht[bidx(bus.br_pc)] = (bht[bidx(bus.br_pc)] == 3) ? 3 : bht[bidx(bus.br_pc)] + 1;
            else              bht[bidx(bus.br_pc)] = (bht[bidx(bus.br_pc)] == 0) ? 0 : bht[bidx(bus.br_pc)] - 1;
        end
`endif
    endtask

    int n_pres = 0;

    initial begin
        bus.icache_valid = 1'b0;
        bus.icache_instr = 32'h0;
        bus.stall_IF     = 1'b0;
        bus.flush        = 1'b0;
        bus.flush_pc     = 32'h0;
        bus.br_commit    = 1'b0;
        bus.br_pc        = 32'h0;
        bus.br_taken     = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            rst              = (c < 3) || (c >= 1500 && c < 1502);
            rdy              = rst ? 1'b1 : ($urandom_range(0, 9) != 0);
            bus.stall_IF     = ($urandom_range(0, 2) == 0);
            bus.flush        = (c > 6) && ($urandom_range(0, 15) == 0);
            bus.flush_pc     = 32'($urandom_range(0, 1023)) << 2;
            bus.br_commit    = ($urandom_range(0, 3) == 0);
            bus.br_pc        = ($urandom_range(0, 1) == 0) ? last_br_pc : (32'($urandom_range(0, 1023)) << 2);
            bus.br_taken     = ($urandom_range(0, 2) != 0);
            bus.icache_valid = busy && (cnt == 0);
            bus.icache_instr = bus.icache_valid ? r_instr : $urandom;
            @(negedge clk);
            model_edge();
        end
        @(posedge clk);
        #4;
        check("presentations", n_pres > 50, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    bit   shown = 0;
    int   idle_cyc = 0;
    exp_t cur;

    always @(posedge clk) begin
        logic rst_edge;
        rst_edge = rst;
        #3;
        if (rst_edge) begin
            check("reset_instr_pc", {bus.instr_pc, bus.instr}, 64'h0);
            check("reset_flags", {bus.instr_valid, bus.is_jump_instr, bus.jump_prediction}, 64'h0);
            shown    = 0;
            idle_cyc = 0;
        end else begin
            check("instr_valid", bus.instr_valid, holding);
            idle_cyc++;
            if (bus.instr_valid) begin
                check("req_while_valid", bus.icache_req, 0);
                if (!shown) begin
                    check("sb_nonempty", sb_q.size() != 0, 1);
                    if (sb_q.size() != 0) begin
                        cur = sb_q.pop_front();
                        n_pres++;
                        idle_cyc = 0;
                        shown    = 1;
                        check("instr_pc", bus.instr_pc, cur.pc);
                        check("instr", bus.instr, cur.instr);
                        check("is_jump_instr", bus.is_jump_instr, cur.isj);
                        check("jump_prediction", bus.jump_prediction, cur.pred);
                    end
                end else begin
                    check("stall_stable", {bus.instr_pc, bus.instr}, {cur.pc, cur.instr});
                end
            end else begin
                shown = 0;
            end
            if (idle_cyc > 400) begin
                check("watchdog_progress", idle_cyc, 0);
                idle_cyc = 0;
            end
        end
    end
endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit feeding the Decoder. Holds the PC, requests 32-bit instructions from the instruction cache, classifies control-transfer instructions, predicts their direction with a 2-bit BHT, and presents one instruction at a time to the Decoder. It honours the Decoder's `stall_IF` back-pressure and redirects on mispredict flushes from the ROB.

## Interface

- `RESET_PC`, 32'h0, PC loaded on reset.
- `BHT_ENTRIES`, 256, BHT size (power of two); index = `pc[log2(BHT_ENTRIES)+1:2]`.
- `clk` input 1 system clock.
- `rst` input 1 synchronous, active-high reset.
- `rdy` input 1 global ready; when low, all state holds.
- `icache_req` output 1 fetch request valid.
- `icache_addr` output 32 fetch address, word aligned.
- `icache_valid` input 1 instruction returned for the outstanding request.
- `icache_instr` input 32 returned instruction.
- `instr_valid` output 1 `instr` holds a valid instruction for the Decoder.
- `instr` output 32 instruction to the Decoder.
- `instr_pc` output 32 PC of `instr`.
- `is_jump_instr` output 1 `instr` is JAL, JALR or BRANCH.
- `jump_prediction` output 1 predicted taken.
- `stall_IF` input 1 Decoder cannot accept this cycle.
- `flush` input 1 mispredict redirect from the ROB.
- `flush_pc` input 32 redirect target.
- `br_commit` input 1 a conditional branch committed.
- `br_pc` input 32 PC of the committed branch.
- `br_taken` input 1 actual outcome of the committed branch.

## Operation

- FSM states:
  - `IDLE`: issue request at `pc` → `WAIT`.
  - `WAIT`: wait for `icache_valid`.
  - `HOLD`: output is valid and the Decoder is stalled.
  - `DROP`: discard one stale response.
- `icache_req`=1 and `icache_addr`=`pc` while in `IDLE`/`WAIT`. Exactly one request is outstanding.
- On `icache_valid` in `WAIT`:
  - Register `instr`, `instr_pc`=`pc`, set `instr_valid`.
  - Compute `next_pc`:
    - JAL (opcode 1101111): taken, `pc`+J-imm.
    - BRANCH (1100011): `pc`+B-imm if the BHT counter MSB is 1, else `pc`+4.
    - JALR (1100111): not taken, `pc`+4.
    - Others: `pc`+4.
  - `is_jump_instr`/`jump_prediction` are set accordingly.
  - Go to `HOLD`.
- In `HOLD`: when `!stall_IF`, the instruction is consumed. Clear `instr_valid`, go to `IDLE`. Outputs stay stable while stalled.
- Flush has the highest priority:
  - Load `pc`=`flush_pc` and clear `instr_valid`.
  - If a request is outstanding and `icache_valid` is not high that cycle, go to `DROP`. Otherwise go to `IDLE`.
  - In `DROP`, the next `icache_valid` is discarded, then go to `IDLE`.
  - A flush while in `DROP` updates `pc` and stays in `DROP`.
- BHT: 2-bit saturating counters, reset to 2'b01. On `br_commit`: increment if `br_taken` (saturate at 3), else decrement (saturate at 0).
- Same-cycle lookup and update at the same index: the lookup sees the old value.
- Immediate arithmetic is 32-bit, sign-extended, and wraps modulo 2^32.

## Timing

- Reset values:
  - `pc`=`RESET_PC`, state=`IDLE`.
  - `instr_valid`=0, `instr`=0, `instr_pc`=0.
  - `is_jump_instr`=0, `jump_prediction`=0, `icache_req`=0.
  - All BHT entries = 01.
- `icache_req` first asserts in the cycle after `rst` deasserts.
- Latency: `icache_valid` in cycle N → `instr_valid` in N+1. With no stall, the next `icache_req` asserts in N+2.
- A request is consumed when `instr_valid && !stall_IF` at the clock edge.
- Flush in cycle N:
  - `instr_valid`=0 in N+1.
  - First request at `flush_pc` in N+1 if no response is pending, otherwise after the dropped response.
- Flush and consume in the same cycle: flush wins and the instruction is discarded.
- `rdy`=0: no state or BHT change. Inputs that cycle are ignored; the icache holds its response until `rdy` returns.
- Reset mid-`WAIT`/`DROP`: return to reset state. The icache is reset by the same `rst`.

## Configuration

- `IFETCH_BHT_EN`:
  - Defined: BHT instantiated and BRANCH predicted as above.
  - Undefined: no BHT storage. BRANCH is always predicted not taken (`jump_prediction`=0, `next_pc`=`pc`+4) and `br_*` inputs are ignored.
  - JAL/JALR handling is identical in both builds.

## Test plan

- Reset, icache returns `addi` (0x00100093) after 2 cycles → `instr_valid`=1 with `instr_pc`=0, `is_jump_instr`=0; next request at 0x4.
- JAL +16 at 0x8 → `is_jump_instr`=1, `jump_prediction`=1; next `icache_addr`=0x18.
- `stall_IF` held 3 cycles with valid output → `instr`/`instr_pc` unchanged, no new `icache_req`; request at +4 the cycle after release.
- BEQ +8 at 0x20, two `br_commit` taken updates for 0x20, then refetch (`IFETCH_BHT_EN` defined) → `jump_prediction`=1, next address 0x28. Undefined → 0, next address 0x24.
- Flush to 0x100 while in `WAIT`, icache responds 2 cycles later → response discarded, `instr_valid` stays 0, next request at 0x100.
- Flush and `!stall_IF` in the same cycle → instruction not re-presented; `instr_valid`=0 the next cycle.
